// File: rtl/uart_pkg.sv
// Shared constants and state encodings for the 8N1 UART PHY.
// Ports: none (package).
package uart_pkg;

  localparam int OVERSAMPLE = 16;
  localparam int DATA_BITS  = 8;
  localparam int BIT_W      = $clog2(DATA_BITS);

  localparam logic [3:0] TICK_S0   = 4'd7;
  localparam logic [3:0] TICK_S1   = 4'd8;
  localparam logic [3:0] TICK_S2   = 4'd9;
  localparam logic [3:0] TICK_LAST = 4'(OVERSAMPLE - 1);

  typedef enum logic [3:0] {
    RX_IDLE  = 4'b0001,
    RX_START = 4'b0010,
    RX_DATA  = 4'b0100,
    RX_STOP  = 4'b1000
  } rx_state_t;

  typedef enum logic [3:0] {
    TX_IDLE  = 4'b0001,
    TX_START = 4'b0010,
    TX_DATA  = 4'b0100,
    TX_STOP  = 4'b1000
  } tx_state_t;

  function automatic logic maj3(
    input logic a,
    input logic b,
    input logic c
  );
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/uart_phy_rx.sv
// UART receive path: rxd/rdn synchronisers, RX FSM with 3-sample vote,
// dout/data_ready holding register. Ports: clk1_8m, rst, rxd, rdn,
// dout, data_ready, frame_err, overrun.
module uart_phy_rx
  import uart_pkg::*;
(
  input  logic                 clk1_8m,
  input  logic                 rst,
  input  logic                 rxd,
  input  logic                 rdn,
  output logic [DATA_BITS-1:0] dout,
  output logic                 data_ready,
  output logic                 frame_err,
  output logic                 overrun
);

  logic rx_s1, rx_s2, rx_d;
  logic rd_s1, rd_s2, rd_d;
  logic rx_fall, rd_fall;

  always_ff @(posedge clk1_8m or negedge rst) begin
    if (!rst) begin
      rx_s1 <= 1'b1;
      rx_s2 <= 1'b1;
      rx_d  <= 1'b1;
      rd_s1 <= 1'b1;
      rd_s2 <= 1'b1;
      rd_d  <= 1'b1;
    end else begin
      rx_s1 <= rxd;
      rx_s2 <= rx_s1;
      rx_d  <= rx_s2;
      rd_s1 <= rdn;
      rd_s2 <= rd_s1;
      rd_d  <= rd_s2;
    end
  end

  assign rx_fall = rx_d & ~rx_s2;
  assign rd_fall = rd_d & ~rd_s2;

  rx_state_t            state;
  logic [3:0]           tick;
  logic [BIT_W-1:0]     bit_cnt;
  logic                 v7, v8;
  logic [DATA_BITS-1:0] shreg;
  logic                 vote;

  assign vote = maj3(v7, v8, rx_s2);

  always_ff @(posedge clk1_8m or negedge rst) begin
    if (!rst) begin
      state      <= RX_IDLE;
      tick       <= '0;
      bit_cnt    <= '0;
      v7         <= 1'b1;
      v8         <= 1'b1;
      shreg      <= '0;
      dout       <= '0;
      data_ready <= 1'b0;
      frame_err  <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      frame_err <= 1'b0;
      overrun   <= 1'b0;
      if (rd_fall) data_ready <= 1'b0;
      if (state != RX_IDLE) tick <= tick + 4'd1;
      if (tick == TICK_S0) v7 <= rx_s2;
      if (tick == TICK_S1) v8 <= rx_s2;
      unique case (state)
        RX_IDLE: begin
          // The edge is seen one sample after the first low sample,
          // so counting resumes at 2 to centre the votes on the bit.
          if (rx_fall) begin
            state <= RX_START;
            tick  <= 4'd2;
          end
        end
        RX_START: begin
          if (tick == TICK_S2 && vote) begin
            state <= RX_IDLE;
          end else if (tick == TICK_LAST) begin
            state   <= RX_DATA;
            bit_cnt <= '0;
          end
        end
        RX_DATA: begin
          if (tick == TICK_S2)
            shreg <= {vote, shreg[DATA_BITS-1:1]};
          if (tick == TICK_LAST) begin
            bit_cnt <= bit_cnt + 1'b1;
            if (bit_cnt == BIT_W'(DATA_BITS - 1))
              state <= RX_STOP;
          end
        end
        RX_STOP: begin
          // Leave half a bit early so the next start edge is never missed.
          if (tick == TICK_S2) begin
            state <= RX_IDLE;
            if (vote) begin
              dout       <= shreg;
              data_ready <= 1'b1;
              overrun    <= data_ready & ~rd_fall;
            end else begin
              frame_err <= 1'b1;
            end
          end
        end
        default: state <= RX_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/uart_phy.sv
// Byte-level 8N1 UART transceiver: TX FSM with wrn handshake and send_over,
// RX path in uart_phy_rx. Ports: clk1_8m, rst, rxd, txd, din, wrn, rdn,
// dout, data_ready, send_over, frame_err, overrun.
module uart_phy
  import uart_pkg::*;
(
  input  logic                 clk1_8m,
  input  logic                 rst,
  input  logic                 rxd,
  output logic                 txd,
  input  logic [DATA_BITS-1:0] din,
  input  logic                 wrn,
  input  logic                 rdn,
  output logic [DATA_BITS-1:0] dout,
  output logic                 data_ready,
  output logic                 send_over,
  output logic                 frame_err,
  output logic                 overrun
);

  uart_phy_rx u_rx (
    .clk1_8m    (clk1_8m),
    .rst        (rst),
    .rxd        (rxd),
    .rdn        (rdn),
    .dout       (dout),
    .data_ready (data_ready),
    .frame_err  (frame_err),
    .overrun    (overrun)
  );

  logic wr_s1, wr_s2, wr_d;
  logic wr_fall;

  always_ff @(posedge clk1_8m or negedge rst) begin
    if (!rst) begin
      wr_s1 <= 1'b1;
      wr_s2 <= 1'b1;
      wr_d  <= 1'b1;
    end else begin
      wr_s1 <= wrn;
      wr_s2 <= wr_s1;
      wr_d  <= wr_s2;
    end
  end

  assign wr_fall = wr_d & ~wr_s2;

  tx_state_t            state;
  logic [3:0]           tick;
  logic [BIT_W-1:0]     bit_cnt;
  logic [DATA_BITS-1:0] shreg;

  always_ff @(posedge clk1_8m or negedge rst) begin
    if (!rst) begin
      state     <= TX_IDLE;
      tick      <= '0;
      bit_cnt   <= '0;
      shreg     <= '0;
      txd       <= 1'b1;
      send_over <= 1'b0;
    end else begin
      if (state != TX_IDLE) tick <= tick + 4'd1;
      unique case (state)
        TX_IDLE: begin
          if (wr_fall) begin
            state     <= TX_START;
            tick      <= '0;
            shreg     <= din;
            txd       <= 1'b0;
            send_over <= 1'b0;
          end
        end
        TX_START: begin
          if (tick == TICK_LAST) begin
            state   <= TX_DATA;
            bit_cnt <= '0;
            txd     <= shreg[0];
          end
        end
        TX_DATA: begin
          if (tick == TICK_LAST) begin
            if (bit_cnt == BIT_W'(DATA_BITS - 1)) begin
              state <= TX_STOP;
              txd   <= 1'b1;
            end else begin
              bit_cnt <= bit_cnt + 1'b1;
              txd     <= shreg[1];
              shreg   <= shreg >> 1;
            end
          end
        end
        TX_STOP: begin
          if (tick == TICK_LAST) begin
            state     <= TX_IDLE;
            send_over <= 1'b1;
          end
        end
        default: state <= TX_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_phy.sv
// Self-checking bench for uart_phy: directed RX frame table plus
// hand-written TX, glitch and reset sequences.
module tb_uart_phy;

  logic       clk1_8m = 1'b0;
  logic       rst = 1'b0;
  logic       rxd = 1'b1;
  logic       wrn = 1'b1;
  logic       rdn = 1'b1;
  logic [7:0] din = 8'h00;
  logic       txd;
  logic [7:0] dout;
  logic       data_ready, send_over, frame_err, overrun;

  int checks = 0;
  int failures = 0;
  int fe_cnt = 0;
  int ov_cnt = 0;

  always #5 clk1_8m = ~clk1_8m;

  uart_phy dut (
    .clk1_8m    (clk1_8m),
    .rst        (rst),
    .rxd        (rxd),
    .txd        (txd),
    .din        (din),
    .wrn        (wrn),
    .rdn        (rdn),
    .dout       (dout),
    .data_ready (data_ready),
    .send_over  (send_over),
    .frame_err  (frame_err),
    .overrun    (overrun)
  );

  always @(negedge clk1_8m) begin
    if (frame_err === 1'b1) fe_cnt++;
    if (overrun === 1'b1) ov_cnt++;
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk1_8m);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // per100 = bit period in hundredths of a cycle (1600 nominal)
  task automatic send_frame(input logic [7:0] b, input logic stop,
                            input int per100);
    logic [9:0] fr;
    int n;
    fr = {stop, b, 1'b0};
    for (int i = 0; i < 10; i++) begin
      n = ((i + 1) * per100) / 100 - (i * per100) / 100;
      rxd = fr[i];
      tick(n);
    end
    rxd = 1'b1;
  endtask

  task automatic read_byte();
    rdn = 1'b0;
    tick(16);
    rdn = 1'b1;
    tick(4);
  endtask

  task automatic tx_frame(input logic [7:0] b, input logic second);
    logic [9:0] txf;
    int k;
    txf = {1'b1, b, 1'b0};
    din = b;
    wrn = 1'b0;
    for (int c = 1; c <= 200; c++) begin
      tick(1);
      if (c == 16 || c == 56) wrn = 1'b1;
      if (second && c == 40) begin
        wrn = 1'b0;
        din = ~b;
      end
      if (c == 2) chk("tx_idle_pre", txd, 1);
      if (c == 3) chk("tx_start_edge", txd, 0);
      if (c == 3) chk("tx_so_clear", send_over, 0);
      if (c == 18) chk("tx_start_end", txd, 0);
      if (c == 19) chk("tx_bit0_edge", txd, txf[1]);
      if (c >= 3 && c < 163 && (c - 3) % 16 == 8) begin
        k = (c - 3) / 16;
        chk($sformatf("tx_bit%0d", k), txd, txf[k]);
      end
      if (c == 162) chk("tx_so_pre", send_over, 0);
      if (c == 163) chk("tx_so_set", send_over, 1);
      if (c == 200) chk("tx_so_hold", send_over, 1);
      if (c == 200) chk("tx_idle_post", txd, 1);
    end
  endtask

  typedef struct {
    logic [7:0] data;
    logic       stop;
    int         per100;
    logic       rd;
    logic [7:0] exp_dout;
    logic       exp_dr;
    int         exp_fe;
    int         exp_ov;
  } vec_t;

  vec_t v[9];

  initial begin
    int fe0, ov0;

    v[0] = '{8'hF5, 1'b1, 1600, 1'b1, 8'hF5, 1'b1, 0, 0};
    v[1] = '{8'h55, 1'b1, 1600, 1'b1, 8'h55, 1'b1, 0, 0};
    v[2] = '{8'h03, 1'b1, 1600, 1'b1, 8'h03, 1'b1, 0, 0};
    v[3] = '{8'hA3, 1'b1, 1600, 1'b1, 8'hA3, 1'b1, 0, 0};
    v[4] = '{8'h3C, 1'b1, 1600, 1'b0, 8'h3C, 1'b1, 0, 0};
    v[5] = '{8'hC9, 1'b1, 1600, 1'b0, 8'hC9, 1'b1, 0, 1};
    v[6] = '{8'h7E, 1'b0, 1600, 1'b1, 8'hC9, 1'b1, 1, 0};
    v[7] = '{8'h96, 1'b1, 1648, 1'b1, 8'h96, 1'b1, 0, 0};
    v[8] = '{8'h69, 1'b1, 1552, 1'b1, 8'h69, 1'b1, 0, 0};

    tick(3);
    chk("rst_txd", txd, 1);
    chk("rst_dout", dout, 8'h00);
    chk("rst_dr", data_ready, 0);
    chk("rst_so", send_over, 0);
    chk("rst_fe", frame_err, 0);
    chk("rst_ov", overrun, 0);
    rst = 1'b1;
    tick(5);

    fork
      send_frame(8'h55, 1'b1, 1600);
      begin
        tick(154);
        chk("rx55_dr_early", data_ready, 0);
        tick(1);
        chk("rx55_dr", data_ready, 1);
        chk("rx55_dout", dout, 8'h55);
      end
    join
    tick(10);
    rdn = 1'b0;
    tick(2);
    chk("rd_dr_hold", data_ready, 1);
    tick(1);
    chk("rd_dr_clear", data_ready, 0);
    tick(13);
    rdn = 1'b1;
    tick(4);

    for (int i = 0; i < 9; i++) begin
      fe0 = fe_cnt;
      ov0 = ov_cnt;
      send_frame(v[i].data, v[i].stop, v[i].per100);
      tick(20);
      chk($sformatf("v%0d_dout", i), dout, v[i].exp_dout);
      chk($sformatf("v%0d_dr", i), data_ready, v[i].exp_dr);
      chk($sformatf("v%0d_fe", i), fe_cnt - fe0, v[i].exp_fe);
      chk($sformatf("v%0d_ov", i), ov_cnt - ov0, v[i].exp_ov);
      if (v[i].rd) begin
        read_byte();
        chk($sformatf("v%0d_rd", i), data_ready, 0);
      end
    end

    fe0 = fe_cnt;
    ov0 = ov_cnt;
    rxd = 1'b0;
    tick(5);
    rxd = 1'b1;
    tick(200);
    chk("glitch_dr", data_ready, 0);
    chk("glitch_dout", dout, 8'h69);
    chk("glitch_flags", (fe_cnt - fe0) + (ov_cnt - ov0), 0);

    tx_frame(8'hF5, 1'b0);
    tx_frame(8'hA3, 1'b1);

    send_frame(8'h5A, 1'b1, 1600);
    tick(20);
    chk("pre_rst_dr", data_ready, 1);
    chk("pre_rst_dout", dout, 8'h5A);
    fe0 = fe_cnt;
    ov0 = ov_cnt;
    din = 8'h00;
    wrn = 1'b0;
    rxd = 1'b0;
    tick(16);
    wrn = 1'b1;
    tick(30);
    chk("pre_rst_txd", txd, 0);
    rst = 1'b0;
    #1;
    chk("mid_rst_txd", txd, 1);
    chk("mid_rst_dout", dout, 8'h00);
    chk("mid_rst_dr", data_ready, 0);
    chk("mid_rst_so", send_over, 0);
    rxd = 1'b1;
    tick(3);
    rst = 1'b1;
    tick(200);
    chk("post_rst_txd", txd, 1);
    chk("post_rst_dr", data_ready, 0);
    chk("post_rst_so", send_over, 0);
    chk("post_rst_flags", (fe_cnt - fe0) + (ov_cnt - ov0), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/uart_phy.md
# uart_phy

Byte-level UART transceiver (8N1, 115200 baud at 1.8432 MHz, 16x oversampling) sitting directly below the command/response controller. It deserialises `rxd` into bytes presented on `dout` with a `data_ready`/`rdn` handshake, and serialises bytes written via `din`/`wrn` onto `txd`, reporting completion on `send_over`. The controller runs on a /16 clock derived from `clk1_8m`, so every handshake input is treated as asynchronous-slow and edge-detected here.

## Interface
- `OVERSAMPLE`, 16: clk1_8m cycles per bit.
- `DATA_BITS`, 8: data bits per frame, LSB first.
- `clk1_8m` in 1: 1.8432 MHz clock; every cycle is one oversample tick.
- `rst` in 1: reset, asynchronous, active-low.
- `rxd` in 1: serial input, idle high, asynchronous.
- `txd` out 1: serial output, idle high.
- `din` in 8: byte to transmit, sampled on accepted write.
- `wrn` in 1: write strobe, active-low; falling edge starts a frame.
- `rdn` in 1: read strobe, active-low; falling edge clears `data_ready`.
- `dout` out 8: last received byte.
- `data_ready` out 1: level, high while an unread byte is in `dout`.
- `send_over` out 1: level, high once a frame finishes; cleared by next accepted write.
- `frame_err` out 1: one-cycle pulse, stop bit sampled low.
- `overrun` out 1: one-cycle pulse, byte completed while `data_ready` already high.

## Operation
- Reset values: `txd`=1, `dout`=8'h00, `data_ready`=0, `send_over`=0, `frame_err`=0, `overrun`=0; both FSMs in IDLE; synchronisers preset to 1.
- `rxd`, `wrn`, `rdn` each pass a 2-flop synchroniser; edges detected on synchronised value vs. one-cycle-delayed copy.
- RX FSM: IDLE -> START on synchronised `rxd` falling edge; tick counter 0..15 per bit.
  - START: majority of samples at ticks 7,8,9; if 1 -> IDLE (glitch rejected, no flags); else -> DATA.
  - DATA: 8 bits, each majority-voted at ticks 7..9, shifted in LSB first -> STOP.
  - STOP: vote at ticks 7..9; 1 -> load `dout`, set `data_ready`, pulse `overrun` if `data_ready` was already 1; 0 -> pulse `frame_err`, `dout`/`data_ready` untouched. Return to IDLE at tick 9 (half-bit early, to tolerate clock skew); next start edge accepted immediately.
- `rdn` falling edge clears `data_ready`. Same cycle as a valid stop: new byte wins, `data_ready` stays 1, no `overrun`.
- TX FSM: IDLE -> START on `wrn` falling edge; latch `din`, clear `send_over`. START (16 cycles `txd`=0), DATA (8x16 cycles, LSB first), STOP (16 cycles `txd`=1), then set `send_over`, -> IDLE.
- `wrn` falling edge while TX not IDLE: ignored, `send_over` stays 0, no frame queued.
- RX and TX independent; full-duplex.

## Timing
- Write latency: `txd` falls 3 cycles after `wrn` low at the pin (2 sync + 1 edge register). Frame = 160 cycles; `send_over` rises the cycle after the stop bit's 16th cycle.
- `send_over` clears within 3 cycles of `wrn` falling, well inside the controller's 16-cycle strobe, so the controller's next sample sees 0.
- Read: `data_ready` clears 3 cycles after `rdn` low. `dout` stable from `data_ready` rise until next valid stop (≥ 153 cycles at back-to-back line rate).
- RX: `data_ready` rises 2 (sync) + 152 (start edge to stop tick 9) + 1 cycles after the `rxd` start edge at the pin.
- Reset mid-frame: `txd` returns to 1 immediately (asynchronous); partial RX byte discarded; no flags.
- Baud tolerance: sampling at ticks 7..9 with restart on each start edge tolerates ±3 % clock mismatch.

## Structure
- Shared package `uart_pkg`: `OVERSAMPLE`, `DATA_BITS`, sample-tick constants (7,8,9), RX/TX state encodings (one-hot, 4 bits each: IDLE, START, DATA, STOP).
- Sub-module `uart_phy_rx`: synchroniser, RX FSM, majority vote, `dout`/`data_ready` register with `rdn` clear. TX FSM, `wrn` sync and `send_over` stay in `uart_phy`.

## Test plan
- Write 8'hF5 via 16-cycle `wrn` pulse -> `txd` 0,1,0,1,0,1,1,1,1,1 each 16 cycles starting 3 cycles after `wrn` low; `send_over` 0 then 1 at cycle 163.
- Drive frame 8'h55 on `rxd` -> `dout`=8'h55, `data_ready`=1 at +155; 16-cycle `rdn` pulse -> `data_ready`=0 3 cycles later.
- Bytes F5, 55, 03, A3 back-to-back, each read before next -> four correct `dout` values, no `overrun`/`frame_err`.
- Two bytes without `rdn` -> `overrun` pulse, `dout`=second byte; frame with stop bit 0 -> `frame_err` pulse, `dout` unchanged.
- 5-cycle low glitch on idle `rxd` -> no `data_ready`, no flags; `rxd` with ±3 % bit period -> correct byte.
- Second `wrn` during transmission -> ignored, single 160-cycle frame; `rst` low mid-frame -> `txd`=1 immediately, all outputs at reset values.
